// File: rtl/sar_search_if.sv
// Handshake bundle between the SAR search engine and its external comparator.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] cand;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output start, gt, lt, eq,
    input  cand, busy, done, found, err, result
  );

  modport slave (
    input  start, gt, lt, eq,
    output cand, busy, done, found, err, result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation (binary) search driving an external combinational
// comparator. Bounds lo/hi shrink toward the target; the search ends on eq,
// on an exhausted range, or on an illegal (non one-hot) flag set.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sar_search_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL   = '1;
  localparam logic [WIDTH-1:0] FIRST_CND = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state;
  logic [WIDTH-1:0] lo, hi, cand_q, result_q;
  logic             busy_q, done_q, found_q, err_q;

  logic [WIDTH-1:0] cand_dec, cand_inc;
  logic [WIDTH:0]   sum_lo, sum_hi;
  logic [WIDTH-1:0] mid_lo, mid_hi;

  // Next-candidate arithmetic; the WIDTH+1 bit sums keep the midpoint exact.
  always_comb begin
    cand_dec = cand_q - 1'b1;
    cand_inc = cand_q + 1'b1;
    sum_lo   = {1'b0, lo} + {1'b0, cand_dec};
    sum_hi   = {1'b0, cand_inc} + {1'b0, hi};
    mid_lo   = sum_lo[WIDTH:1];
    mid_hi   = sum_hi[WIDTH:1];
  end

  // Search FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lo       <= '0;
      hi       <= MAX_VAL;
      cand_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            lo       <= '0;
            hi       <= MAX_VAL;
            cand_q   <= FIRST_CND;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          case ({bus.gt, bus.lt, bus.eq})
            3'b001: begin
              found_q  <= 1'b1;
              result_q <= cand_q;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= DONE;
            end
            3'b100: begin
              // cand > target: a candidate already at lo means the range is empty.
              if (cand_q == lo) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                hi     <= cand_dec;
                cand_q <= mid_lo;
              end
            end
            3'b010: begin
              // cand < target: a candidate already at hi means the range is empty.
              if (cand_q == hi) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                lo     <= cand_inc;
                cand_q <= mid_hi;
              end
            end
            default: begin
              err_q   <= 1'b1;
              found_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          endcase
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.cand   = cand_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: models the comparator against a target
// and checks candidate sequences and end-of-search status.
module tb_sar_search;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   target;
  int   mode;      // 0: honest comparator, 1: gt and lt both high, 2: always lt
  int   n_tests;
  int   n_fail;
  int   exp_seq[$];

  sar_search_if #(.WIDTH(WIDTH)) bus ();

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model answering for the current candidate.
  always_comb begin
    bus.gt = 1'b0;
    bus.lt = 1'b0;
    bus.eq = 1'b0;
    case (mode)
      1: begin
        bus.gt = 1'b1;
        bus.lt = 1'b1;
      end
      2: bus.lt = 1'b1;
      default: begin
        bus.gt = int'(bus.cand) > target;
        bus.lt = int'(bus.cand) < target;
        bus.eq = int'(bus.cand) == target;
      end
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_search(input string tag, input int t, input int m,
                            input int ef, input int ee, input int er);
    int got[$];
    int n;
    int last;
    target = t;
    mode   = m;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      got.push_back(int'(bus.cand));
      n++;
      @(negedge clk);
    end
    check($sformatf("%s cmp_cycles", tag), got.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++)
      check($sformatf("%s cand[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp_seq[i]);
    check($sformatf("%s done", tag), int'(bus.done), 1);
    check($sformatf("%s found", tag), int'(bus.found), ef);
    check($sformatf("%s err", tag), int'(bus.err), ee);
    check($sformatf("%s result", tag), int'(bus.result), er);
    last = int'(bus.cand);
    @(negedge clk);
    check($sformatf("%s done_pulse_len", tag), int'(bus.done), 0);
    check($sformatf("%s cand_hold", tag), int'(bus.cand), last);
    check($sformatf("%s result_hold", tag), int'(bus.result), er);
    mode = 0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    target    = 0;
    mode      = 0;
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst cand", int'(bus.cand), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst found", int'(bus.found), 0);
    check("rst err", int'(bus.err), 0);
    check("rst result", int'(bus.result), 0);

    exp_seq = '{127};
    run_search("t127", 127, 0, 1, 0, 127);

    exp_seq = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("t0", 0, 0, 1, 0, 0);

    exp_seq = '{127};
    run_search("illegal", 50, 1, 0, 1, 0);

    exp_seq = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("beyond", 300, 2, 0, 0, 0);

    exp_seq = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("t255", 255, 0, 1, 0, 255);

    // Reset in the 3rd CMP cycle of a target=200 search.
    target = 200;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("abort cmp1 cand", int'(bus.cand), 127);
    @(negedge clk);
    @(negedge clk);
    check("abort cmp3 cand", int'(bus.cand), 223);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort cand", int'(bus.cand), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort found", int'(bus.found), 0);
    check("abort err", int'(bus.err), 0);
    check("abort result", int'(bus.result), 0);
    @(negedge clk);
    check("abort no_done", int'(bus.done), 0);
    check("abort idle cand", int'(bus.cand), 0);

    exp_seq = '{127, 191, 223, 207, 199, 203, 201, 200};
    run_search("t200", 200, 0, 1, 0, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
